adder_seq_nbit: RTL and testbench



---
 rtl/adder_seq_nbit_pkg.sv | 18 +
 rtl/adder_seq_nbit_if.sv | 29 ++
 rtl/adder_seq_nbit_adder_4bit.sv | 23 ++
 rtl/adder_seq_nbit.sv | 101 ++++++++++
 tb/tb_adder_seq_nbit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_nbit_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding
// and counter sizing.
package adder_seq_nbit_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Nibble counter needs at least one bit even when only one slice exists.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_nbit_if.sv
// Operand/result stream bundle for adder_seq_nbit; the slave side is the adder.
interface adder_seq_nbit_if
    import adder_seq_nbit_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_c;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_s;
    logic         o_c;

    modport master (
        output i_valid, i_a, i_b, i_c, i_ready,
        input  o_ready, o_valid, o_s, o_c
    );

    modport slave (
        input  i_valid, i_a, i_b, i_c, i_ready,
        output o_ready, o_valid, o_s, o_c
    );

endinterface

// File: rtl/adder_seq_nbit_adder_4bit.sv
// Combinational 4-bit ripple-carry adder, the per-nibble datapath of the
// sequential adder.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end

endmodule

// File: rtl/adder_seq_nbit.sv
// Nibble-serial W-bit adder: streams one nibble per cycle through a single
// adder_4bit, chaining the carry through a register, with valid/ready on both sides.
module adder_seq_nbit
    import adder_seq_nbit_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    adder_seq_nbit_if.slave bus
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [W-1:0]          a_sh;
    logic [W-1:0]          b_sh;
    logic [W-1:0]          s_reg;
    logic                  carry;
    logic                  c_reg;
    logic [CNT_W-1:0]      cnt;
    logic [NIBBLE_W-1:0]   nib_s;
    logic                  nib_c;
    logic [W+NIBBLE_W-1:0] s_ext;
    logic                  ready_c;
    logic                  valid_c;
    logic                  last;

    adder_4bit u_adder_4bit (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_c)
    );

    // New nibble enters at the MSB end; written this way so W == 4 needs no special case.
    assign s_ext = {nib_s, s_reg};
    assign last  = (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        valid_c   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.i_valid) state_nxt = S_CALC;
            end
            S_CALC: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                valid_c = 1'b1;
                if (bus.i_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            c_reg <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        a_sh  <= bus.i_a;
                        b_sh  <= bus.i_b;
                        carry <= bus.i_c;
                        cnt   <= '0;
                    end
                end
                S_CALC: begin
                    s_reg <= s_ext[W+NIBBLE_W-1:NIBBLE_W];
                    carry <= nib_c;
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) c_reg <= nib_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = ready_c;
    assign bus.o_valid = valid_c;
    assign bus.o_s     = s_reg;
    assign bus.o_c     = c_reg;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Directed bench for adder_seq_nbit: NIBBLES=4 instance for the main plan,
// NIBBLES=1 instance for the single-slice corner.
module tb_adder_seq_nbit;
    import adder_seq_nbit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    adder_seq_nbit_if #(.NIBBLES(4)) bus4 ();
    adder_seq_nbit_if #(.NIBBLES(1)) bus1 ();

    adder_seq_nbit #(.NIBBLES(4)) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));
    adder_seq_nbit #(.NIBBLES(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand set in IDLE; returns at the negedge after the accept edge.
    task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        check("ready_before_accept", 32'(bus4.o_ready), 32'd1);
        bus4.i_valid = 1'b1;
        bus4.i_a     = a;
        bus4.i_b     = b;
        bus4.i_c     = c;
        @(posedge clk);
        @(negedge clk);
        bus4.i_valid = 1'b0;
    endtask

    task automatic wait_valid4(output int lat);
        lat = 0;
        while (!bus4.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release4();
        bus4.i_ready = 1'b1;
        @(negedge clk);
        bus4.i_ready = 1'b0;
        check("ready_after_release", 32'(bus4.o_ready), 32'd1);
        check("valid_after_release", 32'(bus4.o_valid), 32'd0);
    endtask

    task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] exp, input bit rand_ready);
        int lat;
        int hold;
        start4(a, b, c);
        wait_valid4(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'({bus4.o_c, bus4.o_s}), 32'(exp));
        if (rand_ready) begin
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) @(negedge clk);
            check({tag, "_held"}, 32'({bus4.o_valid, bus4.o_c, bus4.o_s}), 32'({1'b1, exp}));
        end
        release4();
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;

        rst          = 1'b1;
        bus4.i_valid = 1'b0;
        bus4.i_a     = '0;
        bus4.i_b     = '0;
        bus4.i_c     = 1'b0;
        bus4.i_ready = 1'b0;
        bus1.i_valid = 1'b0;
        bus1.i_a     = '0;
        bus1.i_b     = '0;
        bus1.i_c     = 1'b0;
        bus1.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(bus4.o_ready), 32'd1);
        check("reset_valid", 32'(bus4.o_valid), 32'd0);
        check("reset_sum",   32'({bus4.o_c, bus4.o_s}), 32'd0);

        // Basic adds and full carry ripple
        run4("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
        run4("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
        run4("add_ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0);

        // Back-pressure: five cycles of i_ready low in DONE
        start4(16'hA5A5, 16'h1111, 1'b1);
        wait_valid4(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({bus4.o_valid, bus4.o_ready, bus4.o_c, bus4.o_s}),
                  32'({1'b1, 1'b0, 17'h0B6B7}));
        end
        release4();

        // Operands offered during CALC are ignored until IDLE
        start4(16'h1111, 16'h2222, 1'b0);
        bus4.i_valid = 1'b1;
        bus4.i_a     = 16'h0F0F;
        bus4.i_b     = 16'h0101;
        bus4.i_c     = 1'b1;
        wait_valid4(lat);
        check("busy_latency", 32'(lat), 32'd4);
        check("busy_first_sum", 32'({bus4.o_c, bus4.o_s}), 32'h03333);
        bus4.i_ready = 1'b1;
        @(negedge clk);
        bus4.i_ready = 1'b0;
        check("busy_idle_ready", 32'(bus4.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus4.i_valid = 1'b0;
        wait_valid4(lat);
        check("busy_second_latency", 32'(lat), 32'd4);
        check("busy_second_sum", 32'({bus4.o_c, bus4.o_s}), 32'h01011);
        release4();

        // Reset during the second CALC cycle drops the operation
        start4(16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(bus4.o_ready), 32'd1);
        check("midrst_valid", 32'(bus4.o_valid), 32'd0);
        check("midrst_sum",   32'({bus4.o_c, bus4.o_s}), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.o_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        run4("post_rst", 16'h00FF, 16'h0F01, 1'b0, 17'h01000, 1'b0);

        // Random operands with random back-pressure against a+b+c
        for (int n = 0; n < 1000; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rexp = 17'(ra) + 17'(rb) + 17'(rc);
            run4("rand", ra, rb, rc, rexp, 1'b1);
        end

        // Single-slice instance
        @(negedge clk);
        check("n1_ready", 32'(bus1.o_ready), 32'd1);
        bus1.i_valid = 1'b1;
        bus1.i_a     = 4'hF;
        bus1.i_b     = 4'h1;
        bus1.i_c     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus1.i_valid = 1'b0;
        check("n1_calc_valid", 32'(bus1.o_valid), 32'd0);
        @(negedge clk);
        check("n1_done_valid", 32'(bus1.o_valid), 32'd1);
        check("n1_sum", 32'({bus1.o_c, bus1.o_s}), 32'h10);
        bus1.i_ready = 1'b1;
        @(negedge clk);
        check("n1_ready_again", 32'(bus1.o_ready), 32'd1);
        bus1.i_valid = 1'b1;
        bus1.i_a     = 4'h3;
        bus1.i_b     = 4'h4;
        bus1.i_c     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.i_valid = 1'b0;
        @(negedge clk);
        check("n1_sum2", 32'({bus1.o_valid, bus1.o_c, bus1.o_s}), 32'h28);
        @(negedge clk);
        check("n1_done_one_cycle", 32'({bus1.o_valid, bus1.o_ready}), 32'd1);
        bus1.i_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
